tx_baseband_transmitter: RTL and testbench

- Transmit-side counterpart of the baseband receiver's 4:1 gearbox.
- Accepts NUMBER_OF_LINE-sample parallel words over a valid/ready handshake and buffers them in a small FIFO.
- Serializes each word to one sample per clock, oldest sample (MSB slice) first. This inverts the receiver's packing, where the LSB slice holds the newest sample.
- Applies signed Q1.15 gain with rounding and saturation, then drives the DAC-rate sample stream.

---
 rtl/tx_baseband_transmitter.sv | 237 +++++++++++++++++++++++
 tb/tb_tx_baseband_transmitter.sv | 445 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_baseband_transmitter.sv
// -----------------------------------------------------------------------------
// tx_baseband_transmitter
//
// Transmit-side 1:N gearbox. Parallel words of NUMBER_OF_LINE samples are
// queued in a small FIFO, serialized one sample per clock (MSB slice = oldest
// sample goes first), scaled by a signed Q1.15 gain with round-half-up and
// saturation, and driven out as a DAC-rate sample stream.
//
// Optional build feature (macro TX_FS4_MIX_EN): an extra registered stage
// multiplies valid samples by +1, 0, -1, 0 (real fs/4 upconversion). This adds
// one cycle of latency.
//
// Ports:
//   clock            sole clock
//   reset            synchronous, active-high reset
//   data_in          parallel word; slice [N*DW-1 -: DW] is transmitted first
//   data_in_valid    word valid
//   data_in_ready    FIFO not full (registered)
//   enable           transmit enable
//   gain             signed Q1.15 gain, sampled every cycle
//   data_out         serialized, scaled sample (0 when invalid)
//   data_out_valid   data_out carries a real sample
//   underflow_count  saturating count of underflow events
// -----------------------------------------------------------------------------
module tx_baseband_transmitter #(
  parameter int NUMBER_OF_LINE = 4,
  parameter int DATA_WIDTH     = 16,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [NUMBER_OF_LINE*DATA_WIDTH-1:0] data_in,
  input  logic                                 data_in_valid,
  output logic                                 data_in_ready,
  input  logic                                 enable,
  input  logic [15:0]                          gain,
  output logic [DATA_WIDTH-1:0]                data_out,
  output logic                                 data_out_valid,
  output logic [15:0]                          underflow_count
);

  localparam int WW = NUMBER_OF_LINE * DATA_WIDTH;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int LW = (NUMBER_OF_LINE > 1) ? $clog2(NUMBER_OF_LINE) : 1;
  localparam int PW = DATA_WIDTH + 16;

  localparam logic [LW-1:0] LANE_FIRST = (NUMBER_OF_LINE > 1) ? LW'(1) : '0;
  localparam logic [LW-1:0] LANE_LAST  = LW'(NUMBER_OF_LINE - 1);
  localparam logic [CW-1:0] COUNT_FULL = CW'(FIFO_DEPTH);

  localparam logic signed [PW-1:0] RND_HALF = PW'(16384);
  localparam logic signed [PW-1:0] SAT_MAX  = PW'((2 ** (DATA_WIDTH - 1)) - 1);
  localparam logic signed [PW-1:0] SAT_MIN  = ~SAT_MAX;

  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

  // ---------------------------------------------------------------- FIFO
  logic [WW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_next;
  logic [WW-1:0] head;
  logic          push, pop;

  state_t            state;
  logic [LW-1:0]     lane;
  logic [DATA_WIDTH-1:0] ser_q;
  logic [WW-1:0]     shift_q;
  logic              ser_valid;

  assign push = data_in_valid && data_in_ready;
  assign head = mem[rd_ptr];

  // Pop decision is shared by the FIFO pointers and the FSM load path.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    pop = 1'b0;
    case (state)
      PRIME:   pop = enable && (count >= CW'(2));
      RUN:     pop = enable && (lane == '0) && (count != '0);
      default: pop = 1'b0;
    endcase
  end

  always_comb begin
    count_next = count;
    if (push && !pop)      count_next = count + CW'(1);
    else if (pop && !push) count_next = count - CW'(1);
  end

  // NOTE: word storage carries no reset; emptiness is defined by the pointers
  // and count, so clearing the array would only cost reset fan-out.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      data_in_ready <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count         <= count_next;
      data_in_ready <= (count_next != COUNT_FULL);
    end
  end

  // ---------------------------------------------------------------- FSM
  // lane is the index of the next slice to present; lane == 0 while in RUN
  // means the last slice of the current word is on ser_q (word boundary).
  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= IDLE;
      lane            <= '0;
      ser_q           <= '0;
      shift_q         <= '0;
      ser_valid       <= 1'b0;
      underflow_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          ser_valid <= 1'b0;
          if (enable) state <= PRIME;
        end
        PRIME: begin
          if (!enable) begin
            state <= IDLE;
          end else if (pop) begin
            ser_q     <= head[WW-1 -: DATA_WIDTH];
            shift_q   <= head << DATA_WIDTH;
            lane      <= LANE_FIRST;
            ser_valid <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          if (lane != '0) begin
            ser_q   <= shift_q[WW-1 -: DATA_WIDTH];
            shift_q <= shift_q << DATA_WIDTH;
            lane    <= (lane == LANE_LAST) ? '0 : lane + LW'(1);
          end else if (pop) begin
            // Next word follows the previous one with no gap.
            ser_q   <= head[WW-1 -: DATA_WIDTH];
            shift_q <= head << DATA_WIDTH;
            lane    <= LANE_FIRST;
          end else if (!enable) begin
            ser_valid <= 1'b0;
            state     <= IDLE;
          end else begin
            ser_valid <= 1'b0;
            state     <= PRIME;
            if (underflow_count != 16'hFFFF)
              underflow_count <= underflow_count + 16'd1;
          end
        end
        default: begin
          ser_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------- gain
  logic signed [PW-1:0]  prod, rnd;
  logic [DATA_WIDTH-1:0] scaled;
  logic [DATA_WIDTH-1:0] g_q;
  logic                  g_valid;

  always_comb begin
    prod = PW'($signed(ser_q)) * PW'($signed(gain));
    rnd  = (prod + RND_HALF) >>> 15;
    if (rnd > SAT_MAX)      scaled = SAT_MAX[DATA_WIDTH-1:0];
    else if (rnd < SAT_MIN) scaled = SAT_MIN[DATA_WIDTH-1:0];
    else                    scaled = rnd[DATA_WIDTH-1:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      g_q     <= '0;
      g_valid <= 1'b0;
    end else begin
      g_valid <= ser_valid;
      g_q     <= ser_valid ? scaled : '0;
    end
  end

`ifdef TX_FS4_MIX_EN
  // ---------------------------------------------------------------- fs/4 mix
  localparam logic [DATA_WIDTH-1:0] D_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] D_MAX = ~D_MIN;

  logic [1:0]            phase, eff_phase;
  logic [DATA_WIDTH-1:0] neg;
  logic [DATA_WIDTH-1:0] m_q;
  logic                  m_valid;

  // Every valid run starts with a PRIME->RUN load, and PRIME/IDLE always leave
  // a gap, so a rising edge of g_valid marks the start of a run: the phase
  // restarts at 0 there.
  always_comb begin
    eff_phase = m_valid ? phase : 2'd0;
    neg       = (g_q == D_MIN) ? D_MAX : (~g_q + DATA_WIDTH'(1));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      phase   <= 2'd0;
      m_q     <= '0;
      m_valid <= 1'b0;
    end else begin
      m_valid <= g_valid;
      if (g_valid) begin
        phase <= eff_phase + 2'd1;
        case (eff_phase)
          2'd0:    m_q <= g_q;
          2'd2:    m_q <= neg;
          default: m_q <= '0;
        endcase
      end else begin
        m_q <= '0;
      end
    end
  end

  assign data_out       = m_q;
  assign data_out_valid = m_valid;
`else
  assign data_out       = g_q;
  assign data_out_valid = g_valid;
`endif

endmodule

// File: tb/tb_tx_baseband_transmitter.sv
// -----------------------------------------------------------------------------
// Self-checking bench for tx_baseband_transmitter (default parameters).
// Expected streams come from a sample-level model: words are expanded into
// samples oldest-first, scaled with integer Q1.15 arithmetic, and (with
// TX_FS4_MIX_EN) multiplied by +1,0,-1,0 according to position within a run.
// -----------------------------------------------------------------------------
module tb_tx_baseband_transmitter;

`ifdef TX_FS4_MIX_EN
  localparam bit MIX = 1'b1;
`else
  localparam bit MIX = 1'b0;
`endif
  // Edges from the 2nd push to the first valid sample on data_out.
  localparam int LAT = MIX ? 3 : 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] data_in = '0;
  logic        data_in_valid = 1'b0;
  logic        data_in_ready;
  logic        enable = 1'b0;
  logic [15:0] gain = 16'h7FFF;
  logic [15:0] data_out;
  logic        data_out_valid;
  logic [15:0] underflow_count;

  int n_cmp = 0;
  int n_bad = 0;

  logic [16:0] exp_tr[$];   // {valid, data} per cycle
  logic [16:0] got_tr[$];

  tx_baseband_transmitter dut (
    .clock           (clock),
    .reset           (reset),
    .data_in         (data_in),
    .data_in_valid   (data_in_valid),
    .data_in_ready   (data_in_ready),
    .enable          (enable),
    .gain            (gain),
    .data_out        (data_out),
    .data_out_valid  (data_out_valid),
    .underflow_count (underflow_count)
  );

  always #5 clock = ~clock;

  // ---------------------------------------------------------------- model
  function automatic logic [15:0] scale(input logic [15:0] s, input logic [15:0] g);
    longint p, r;
    p = longint'($signed(s)) * longint'($signed(g));
    r = (p + 64'sd16384) >>> 15;
    if (r > 32767)  r = 32767;
    if (r < -32768) r = -32768;
    return r[15:0];
  endfunction

  function automatic logic [15:0] mix_apply(input int pos, input logic [15:0] x);
    if (!MIX) return x;
    case (pos % 4)
      0:       return x;
      2:       return (x == 16'h8000) ? 16'h7FFF : 16'(-$signed(x));
      default: return 16'h0000;
    endcase
  endfunction

  task automatic exp_idle(input int n);
    repeat (n) exp_tr.push_back(17'h0);
  endtask

  // One contiguous run made of the given words.
  task automatic exp_words(input logic [63:0] w[$], input logic [15:0] g);
    logic [63:0] cur;
    int pos;
    pos = 0;
    foreach (w[i]) begin
      cur = w[i];
      for (int l = 0; l < 4; l++) begin
        exp_tr.push_back({1'b1, mix_apply(pos, scale(cur[63-16*l -: 16], g))});
        pos++;
      end
    end
  endtask

  function automatic logic [63:0] rand_word();
    return {$urandom, $urandom};
  endfunction

  // ---------------------------------------------------------------- drivers
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    enable = 1'b0;
    data_in_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic push_word(input logic [63:0] w);
    logic acc;
    int tries;
    tries = 0;
    data_in = w;
    data_in_valid = 1'b1;
    do begin
      acc = data_in_ready;
      step();
      tries++;
    end while (!acc && tries < 100);
    data_in_valid = 1'b0;
    if (!acc) begin
      n_cmp++;
      n_bad++;
      $display("FAIL push_timeout: data_in_ready=0 for %0d cycles, expected 1", tries);
    end
  endtask

  task automatic capture(input int n);
    got_tr.delete();
    repeat (n) begin
      step();
      got_tr.push_back({data_out_valid, data_out});
    end
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    do_reset();
    n_cmp += 4;
    if (data_out !== 16'h0) begin n_bad++; $display("FAIL reset_data: got %h expected 0000", data_out); end
    if (data_out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b expected 0", data_out_valid); end
    if (underflow_count !== 16'h0) begin n_bad++; $display("FAIL reset_uf: got %h expected 0000", underflow_count); end
    if (data_in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b expected 1", data_in_ready); end
  endtask

  task automatic test_unity();
    logic [63:0] w[$];
    w = '{64'h4000_3000_2000_1000, 64'h0400_0300_0200_0100};
    do_reset();
    enable = 1'b1;
    gain = 16'h7FFF;
    step();
    push_word(w[0]);
    push_word(w[1]);
    exp_tr.delete();
    exp_idle(LAT - 1);
    exp_words(w, gain);
    exp_idle(2);
    capture(exp_tr.size());
    for (int k = 0; k < exp_tr.size(); k++) begin
      n_cmp++;
      if (got_tr[k] !== exp_tr[k]) begin
        n_bad++;
        $display("FAIL unity[%0d]: got valid=%b data=%h, expected valid=%b data=%h",
                 k, got_tr[k][16], got_tr[k][15:0], exp_tr[k][16], exp_tr[k][15:0]);
      end
    end
    n_cmp++;
    if (underflow_count !== 16'd1) begin
      n_bad++;
      $display("FAIL unity_uf: got %0d expected 1", underflow_count);
    end
  endtask

  task automatic test_scaling();
    logic [15:0] s_tab[3] = '{16'h8000, 16'h4000, 16'h1000};
    logic [15:0] g_tab[3] = '{16'h8000, 16'h4000, 16'hC000};
    logic [15:0] r_tab[3] = '{16'h7FFF, 16'h2000, 16'hF800};
    logic [63:0] w[$];
    for (int c = 0; c < 3; c++) begin
      w = '{{4{s_tab[c]}}, {4{s_tab[c]}}};
      do_reset();
      enable = 1'b1;
      gain = g_tab[c];
      step();
      push_word(w[0]);
      push_word(w[1]);
      exp_tr.delete();
      exp_idle(LAT - 1);
      exp_words(w, gain);
      exp_idle(1);
      capture(exp_tr.size());
      n_cmp++;
      if (got_tr[LAT-1] !== {1'b1, r_tab[c]}) begin
        n_bad++;
        $display("FAIL scale_const%0d: got %h expected %h", c, got_tr[LAT-1][15:0], r_tab[c]);
      end
      for (int k = 0; k < exp_tr.size(); k++) begin
        n_cmp++;
        if (got_tr[k] !== exp_tr[k]) begin
          n_bad++;
          $display("FAIL scale%0d[%0d]: got valid=%b data=%h, expected valid=%b data=%h",
                   c, k, got_tr[k][16], got_tr[k][15:0], exp_tr[k][16], exp_tr[k][15:0]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] w[$];
    do_reset();
    gain = 16'($urandom);
    for (int i = 0; i < 4; i++) begin
      w.push_back(rand_word());
      n_cmp++;
      if (data_in_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL bp_ready_before%0d: got %b expected 1", i, data_in_ready);
      end
      push_word(w[i]);
    end
    n_cmp++;
    if (data_in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_ready_full: got %b expected 0", data_in_ready);
    end
    // A fifth word offered while full must be refused.
    data_in = rand_word();
    data_in_valid = 1'b1;
    exp_tr.delete();
    exp_idle(3);
    capture(3);
    data_in_valid = 1'b0;
    enable = 1'b1;
    exp_idle(MIX ? 3 : 2);
    exp_words(w, gain);
    exp_idle(2);
    begin
      logic [16:0] head3[$];
      head3 = got_tr;
      capture(exp_tr.size() - 3);
      got_tr = {head3, got_tr};
    end
    for (int k = 0; k < exp_tr.size(); k++) begin
      n_cmp++;
      if (got_tr[k] !== exp_tr[k]) begin
        n_bad++;
        $display("FAIL backpressure[%0d]: got valid=%b data=%h, expected valid=%b data=%h",
                 k, got_tr[k][16], got_tr[k][15:0], exp_tr[k][16], exp_tr[k][15:0]);
      end
    end
    n_cmp++;
    if (underflow_count !== 16'd1) begin
      n_bad++;
      $display("FAIL bp_uf: got %0d expected 1", underflow_count);
    end
  endtask

  task automatic test_enable_drop();
    logic [63:0] w[$];
    w = '{rand_word(), rand_word(), rand_word()};
    do_reset();
    gain = 16'($urandom);
    enable = 1'b1;
    step();
    push_word(w[0]);
    push_word(w[1]);
    push_word(w[2]);      // first word now on the serializer with lane=1
    enable = 1'b0;
    exp_tr.delete();
    exp_idle(MIX ? 1 : 0);
    exp_words('{w[0]}, gain);
    exp_idle(5);
    capture(exp_tr.size());
    for (int k = 0; k < exp_tr.size(); k++) begin
      n_cmp++;
      if (got_tr[k] !== exp_tr[k]) begin
        n_bad++;
        $display("FAIL enable_drop[%0d]: got valid=%b data=%h, expected valid=%b data=%h",
                 k, got_tr[k][16], got_tr[k][15:0], exp_tr[k][16], exp_tr[k][15:0]);
      end
    end
    n_cmp++;
    if (underflow_count !== 16'd0) begin
      n_bad++;
      $display("FAIL enable_drop_uf: got %0d expected 0", underflow_count);
    end
  endtask

  task automatic test_reset_mid_word();
    logic [63:0] w[$];
    do_reset();
    gain = 16'h7FFF;
    enable = 1'b1;
    step();
    push_word(rand_word());
    push_word(rand_word());
    push_word(rand_word());
    repeat (3) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_cmp += 4;
    if (data_out_valid !== 1'b0) begin n_bad++; $display("FAIL midreset_valid: got %b expected 0", data_out_valid); end
    if (data_out !== 16'h0) begin n_bad++; $display("FAIL midreset_data: got %h expected 0000", data_out); end
    if (underflow_count !== 16'h0) begin n_bad++; $display("FAIL midreset_uf: got %h expected 0000", underflow_count); end
    if (data_in_ready !== 1'b1) begin n_bad++; $display("FAIL midreset_ready: got %b expected 1", data_in_ready); end
    // With the FIFO truly empty, one new word alone must not start output.
    w = '{rand_word(), rand_word()};
    enable = 1'b1;
    push_word(w[0]);
    exp_tr.delete();
    exp_idle(10);
    capture(10);
    push_word(w[1]);
    exp_idle(LAT - 1);
    exp_words(w, gain);
    exp_idle(1);
    begin
      logic [16:0] pre[$];
      pre = got_tr;
      capture(exp_tr.size() - 10);
      got_tr = {pre, got_tr};
    end
    for (int k = 0; k < exp_tr.size(); k++) begin
      n_cmp++;
      if (got_tr[k] !== exp_tr[k]) begin
        n_bad++;
        $display("FAIL midreset[%0d]: got valid=%b data=%h, expected valid=%b data=%h",
                 k, got_tr[k][16], got_tr[k][15:0], exp_tr[k][16], exp_tr[k][15:0]);
      end
    end
  endtask

`ifdef TX_FS4_MIX_EN
  task automatic test_mix();
    logic [15:0] seq[4] = '{16'h1000, 16'h0000, 16'hF000, 16'h0000};
    do_reset();
    gain = 16'h7FFF;
    enable = 1'b1;
    step();
    push_word({4{16'h1000}});
    push_word({4{16'h1000}});
    capture(LAT + 7);
    for (int k = 0; k < LAT + 7; k++) begin
      n_cmp++;
      if (k < LAT - 1) begin
        if (got_tr[k][16] !== 1'b0) begin
          n_bad++;
          $display("FAIL mix_lead[%0d]: got valid=%b expected 0", k, got_tr[k][16]);
        end
      end else if (got_tr[k] !== {1'b1, seq[(k-LAT+1)%4]}) begin
        n_bad++;
        $display("FAIL mix[%0d]: got valid=%b data=%h, expected valid=1 data=%h",
                 k, got_tr[k][16], got_tr[k][15:0], seq[(k-LAT+1)%4]);
      end
    end
  endtask
`endif

  // Random words pushed in back-to-back pairs with random gaps; output is
  // checked as an ordered sample stream split into runs.
  task automatic test_random(input int npairs);
    logic [63:0] w[$];
    logic [15:0] exp_s[$];
    logic [63:0] cur;
    int idx, runs, run_len, cyc;
    logic prev;
    do_reset();
    gain = 16'($urandom);
    enable = 1'b1;
    step();
    for (int i = 0; i < 2 * npairs; i++) begin
      cur = rand_word();
      w.push_back(cur);
      for (int l = 0; l < 4; l++) exp_s.push_back(scale(cur[63-16*l -: 16], gain));
    end
    idx = 0; runs = 0; run_len = 0; cyc = 0; prev = 1'b0;
    fork
      begin
        for (int p = 0; p < npairs; p++) begin
          repeat ($urandom_range(0, 6)) step();
          push_word(w[2*p]);
          push_word(w[2*p+1]);
        end
      end
      begin
        while (cyc < 3000) begin
          step();
          cyc++;
          if (data_out_valid) begin
            n_cmp++;
            if (idx >= exp_s.size()) begin
              n_bad++;
              $display("FAIL random_extra: got sample %h, expected none", data_out);
            end else if (data_out !== mix_apply(run_len, exp_s[idx])) begin
              n_bad++;
              $display("FAIL random[%0d]: got %h expected %h", idx, data_out,
                       mix_apply(run_len, exp_s[idx]));
            end
            idx++;
            run_len++;
          end else if (prev) begin
            n_cmp++;
            if (run_len % 4 != 0 || run_len < 8) begin
              n_bad++;
              $display("FAIL random_runlen: got %0d, expected multiple of 4 and >= 8", run_len);
            end
            runs++;
            run_len = 0;
          end
          prev = data_out_valid;
          if (idx >= exp_s.size() && !data_out_valid) break;
        end
      end
    join
    n_cmp += 2;
    if (idx != exp_s.size()) begin
      n_bad++;
      $display("FAIL random_count: got %0d samples, expected %0d", idx, exp_s.size());
    end
    if (underflow_count !== 16'(runs)) begin
      n_bad++;
      $display("FAIL random_uf: got %0d expected %0d", underflow_count, runs);
    end
  endtask

  initial begin
    test_reset();
    test_unity();
    test_scaling();
    test_backpressure();
    test_enable_drop();
    test_reset_mid_word();
`ifdef TX_FS4_MIX_EN
    test_mix();
`endif
    test_random(10);
    test_random(12);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
